time_display_driver: RTL and testbench

TIME_DISPLAY_DRIVER -- requirements
Module: time_display_driver

---
 rtl/time_display_pkg.sv | 44 ++++
 rtl/seven_segment_decoder.sv | 28 ++
 rtl/time_display_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_time_display_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_display_pkg.sv
// Shared types and constants for the multiplexed time display driver.
package time_display_pkg;

   localparam int NUM_DIGITS = 8;

   // Conversion sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CONV_H,
      ST_CONV_M,
      ST_CONV_S,
      ST_CONV_C,
      ST_COMMIT
   } conv_state_t;

   // Per-digit code: 0-9 are numerals, plus two special glyphs
   typedef logic [3:0] digit_code_t;
   typedef digit_code_t [NUM_DIGITS-1:0] digit_buf_t;

   localparam digit_code_t CODE_BLANK = 4'hA;
   localparam digit_code_t CODE_DASH  = 4'hB;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Largest legal value of each time field
   localparam logic [4:0] MAX_HOURS   = 5'd23;
   localparam logic [5:0] MAX_MINUTES = 6'd59;
   localparam logic [5:0] MAX_SECONDS = 6'd59;
   localparam logic [6:0] MAX_CENTIS  = 7'd99;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational digit-code to active-low seven-segment pattern decoder.
module seven_segment_decoder
   import time_display_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] segments
);

   // Map each code to its glyph; unused codes show nothing
   always_comb begin
      segments = SEG_BLANK;
      case (code)
         4'd0:       segments = SEG_0;
         4'd1:       segments = SEG_1;
         4'd2:       segments = SEG_2;
         4'd3:       segments = SEG_3;
         4'd4:       segments = SEG_4;
         4'd5:       segments = SEG_5;
         4'd6:       segments = SEG_6;
         4'd7:       segments = SEG_7;
         4'd8:       segments = SEG_8;
         4'd9:       segments = SEG_9;
         CODE_DASH:  segments = SEG_DASH;
         default:    segments = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/time_display_driver.sv
// Eight-digit multiplexed HH.MM.SS.CC display driver: scans digits,
// converts snapshotted binary time to BCD once per frame, blinks on alarm.
module time_display_driver
   import time_display_pkg::*;
#(
   parameter int SCAN_DIV     = 4,
   parameter int BLINK_FRAMES = 8
)
(
   input  logic       clockSignal,
   input  logic       resetSignal,
   input  logic [4:0] hoursIn,
   input  logic [5:0] minutesIn,
   input  logic [5:0] secondsIn,
   input  logic [6:0] centisecondsIn,
   input  logic       ringSound,
   output logic [7:0] digitSelect,
   output logic [6:0] segments,
   output logic       decimalPoint,
   output logic       busy
);

   localparam logic [9:0] SCAN_LAST  = 10'(SCAN_DIV - 1);
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   // Scan state
   logic [9:0]  cycleCount;
   logic [2:0]  digitIndex;
   logic        scanStep;
   logic        frameWrap;

   // Blink state
   logic [7:0]  frameCount;
   logic        blankPhase;

   // Conversion state
   conv_state_t state;
   logic [4:0]  snapHours;
   logic [5:0]  snapMinutes;
   logic [5:0]  snapSeconds;
   logic [6:0]  snapCentis;
   logic [6:0]  remainder;
   logic [3:0]  tensCount;
   digit_buf_t  staging;
   digit_buf_t  displayBuffer;

   // Per-field combinational helpers
   logic        fieldOutOfRange;
   logic        fieldDone;
   logic [6:0]  nextRemainder;
   conv_state_t nextFieldState;
   logic [2:0]  tensSlot;
   logic [2:0]  onesSlot;
   digit_code_t tensCode;
   digit_code_t onesCode;

   // Display path
   digit_code_t selectedCode;
   logic [6:0]  decodedSegments;

   // Scan step and frame boundary detection
   always_comb begin
      scanStep  = (cycleCount == SCAN_LAST);
      frameWrap = scanStep && (digitIndex == 3'd7);
   end

   // Digit scan counters
   always_ff @(posedge clockSignal) begin
      if (resetSignal) begin
         cycleCount <= '0;
         digitIndex <= '0;
      end else if (scanStep) begin
         cycleCount <= '0;
         digitIndex <= digitIndex + 3'd1;
      end else begin
         cycleCount <= cycleCount + 10'd1;
      end
   end

   // Blink phase: toggles every BLINK_FRAMES frames while ringing, lit otherwise
   always_ff @(posedge clockSignal) begin
      if (resetSignal || !ringSound) begin
         frameCount <= '0;
         blankPhase <= 1'b0;
      end else if (frameWrap) begin
         if (frameCount == BLINK_LAST) begin
            frameCount <= '0;
            blankPhase <= ~blankPhase;
         end else begin
            frameCount <= frameCount + 8'd1;
         end
      end
   end

   // Select the field being converted and what follows it
   always_comb begin
      fieldOutOfRange = 1'b0;
      nextRemainder   = '0;
      nextFieldState  = ST_IDLE;
      tensSlot        = 3'd0;
      case (state)
         ST_CONV_H: begin
            fieldOutOfRange = (snapHours > MAX_HOURS);
            nextRemainder   = {1'b0, snapMinutes};
            nextFieldState  = ST_CONV_M;
            tensSlot        = 3'd7;
         end
         ST_CONV_M: begin
            fieldOutOfRange = (snapMinutes > MAX_MINUTES);
            nextRemainder   = {1'b0, snapSeconds};
            nextFieldState  = ST_CONV_S;
            tensSlot        = 3'd5;
         end
         ST_CONV_S: begin
            fieldOutOfRange = (snapSeconds > MAX_SECONDS);
            nextRemainder   = snapCentis;
            nextFieldState  = ST_CONV_C;
            tensSlot        = 3'd3;
         end
         ST_CONV_C: begin
            fieldOutOfRange = (snapCentis > MAX_CENTIS);
            nextRemainder   = '0;
            nextFieldState  = ST_COMMIT;
            tensSlot        = 3'd1;
         end
         default: ;
      endcase
      onesSlot  = tensSlot - 3'd1;
      fieldDone = fieldOutOfRange || (remainder < 7'd10);
   end

   // Digit codes stored when a field finishes
   always_comb begin
      tensCode = digit_code_t'(tensCount);
      onesCode = digit_code_t'(remainder[3:0]);
      if (fieldOutOfRange) begin
         tensCode = CODE_DASH;
         onesCode = CODE_DASH;
      end else if ((state == ST_CONV_H) && (tensCount == 4'd0)) begin
         tensCode = CODE_BLANK;
      end
   end

   // Conversion FSM: snapshot at frame wrap, repeated-subtraction BCD, commit
   always_ff @(posedge clockSignal) begin
      if (resetSignal) begin
         state         <= ST_IDLE;
         busy          <= 1'b0;
         snapHours     <= '0;
         snapMinutes   <= '0;
         snapSeconds   <= '0;
         snapCentis    <= '0;
         remainder     <= '0;
         tensCount     <= '0;
         staging       <= {NUM_DIGITS{CODE_BLANK}};
         displayBuffer <= {NUM_DIGITS{CODE_BLANK}};
      end else begin
         case (state)
            ST_IDLE: begin
               if (frameWrap) begin
                  snapHours   <= hoursIn;
                  snapMinutes <= minutesIn;
                  snapSeconds <= secondsIn;
                  snapCentis  <= centisecondsIn;
                  state       <= ST_LOAD;
                  busy        <= 1'b1;
               end
            end
            ST_LOAD: begin
               remainder <= {2'b00, snapHours};
               tensCount <= '0;
               state     <= ST_CONV_H;
            end
            ST_CONV_H, ST_CONV_M, ST_CONV_S, ST_CONV_C: begin
               // Out-of-range fields skip subtraction and store dashes at once
               if (!fieldDone) begin
                  remainder <= remainder - 7'd10;
                  tensCount <= tensCount + 4'd1;
               end else begin
                  staging[tensSlot] <= tensCode;
                  staging[onesSlot] <= onesCode;
                  remainder         <= nextRemainder;
                  tensCount         <= '0;
                  state             <= nextFieldState;
               end
            end
            ST_COMMIT: begin
               displayBuffer <= staging;
               state         <= ST_IDLE;
               busy          <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Code of the currently scanned digit
   always_comb begin
      selectedCode = displayBuffer[digitIndex];
   end

   seven_segment_decoder u_decoder (
      .code     (selectedCode),
      .segments (decodedSegments)
   );

   // Registered display outputs, one cycle behind the scan index
   always_ff @(posedge clockSignal) begin
      if (resetSignal) begin
         digitSelect  <= '1;
         segments     <= SEG_BLANK;
         decimalPoint <= 1'b1;
      end else begin
         digitSelect  <= (blankPhase && ringSound) ? 8'hFF : ~(8'b1 << digitIndex);
         segments     <= decodedSegments;
         decimalPoint <= ~((digitIndex == 3'd2) || (digitIndex == 3'd4) ||
                           (digitIndex == 3'd6));
      end
   end

endmodule

// File: tb/tb_time_display_driver.sv
// Self-checking bench for time_display_driver: cycle model plus directed checks.
module tb_time_display_driver;

   localparam int S     = 4;
   localparam int BF    = 2;
   localparam int FRAME = 8 * S;

   logic       clockSignal = 1'b0;
   logic       resetSignal;
   logic [4:0] hoursIn;
   logic [5:0] minutesIn;
   logic [5:0] secondsIn;
   logic [6:0] centisecondsIn;
   logic       ringSound;
   logic [7:0] digitSelect;
   logic [6:0] segments;
   logic       decimalPoint;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   time_display_driver #(.SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
      .clockSignal    (clockSignal),
      .resetSignal    (resetSignal),
      .hoursIn        (hoursIn),
      .minutesIn      (minutesIn),
      .secondsIn      (secondsIn),
      .centisecondsIn (centisecondsIn),
      .ringSound      (ringSound),
      .digitSelect    (digitSelect),
      .segments       (segments),
      .decimalPoint   (decimalPoint),
      .busy           (busy)
   );

   always #5 clockSignal = ~clockSignal;

   // Glyph table: codes 0-9 numerals, 10 blank, 11 dash
   function automatic logic [6:0] segOf(input int code);
      case (code)
         0:  return 7'b1000000;
         1:  return 7'b1111001;
         2:  return 7'b0100100;
         3:  return 7'b0110000;
         4:  return 7'b0011001;
         5:  return 7'b0010010;
         6:  return 7'b0000010;
         7:  return 7'b1111000;
         8:  return 7'b0000000;
         9:  return 7'b0010000;
         11: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   // Decimal digits of a field and the cycles its conversion takes
   function automatic void fieldModel(input int v, input int maxv, input bit isHour,
                                      output int tens, output int ones, output int cyc);
      if (v > maxv) begin
         tens = 11; ones = 11; cyc = 1;
      end else begin
         tens = v / 10; ones = v % 10; cyc = v / 10 + 1;
         if (isHour && tens == 0) tens = 10;
      end
   endfunction

   // Behavioural model: time since reset determines scan position and frame wraps
   int k;
   bit pending;
   int commitEdge;
   int mBuf[8];
   int pendBuf[8];
   int ringFrames;
   bit modelValid = 1'b0;
   logic [7:0] expSel;
   logic [6:0] expSeg;
   logic       expDp;
   logic       expBusy;

   always @(posedge clockSignal) begin
      int idx, t, o, c, lat;
      bit frameWrap, doSnap, blank;
      if (resetSignal) begin
         k = 0; pending = 0; commitEdge = 0; ringFrames = 0;
         for (int i = 0; i < 8; i++) mBuf[i] = 10;
         expSel = 8'hFF; expSeg = 7'h7F; expDp = 1'b1; expBusy = 1'b0;
      end else begin
         k++;
         idx = ((k - 1) / S) % 8;
         frameWrap = (k % FRAME) == 0;
         blank = ringSound && (((ringFrames / BF) % 2) == 1);
         expSel = blank ? 8'hFF : ~(8'b1 << idx);
         expSeg = segOf(mBuf[idx]);
         expDp  = !(idx == 2 || idx == 4 || idx == 6);
         doSnap = frameWrap && !pending;
         if (pending && k == commitEdge) begin
            mBuf = pendBuf;
            pending = 0;
         end
         if (doSnap) begin
            lat = 2;
            fieldModel(hoursIn, 23, 1'b1, t, o, c);        pendBuf[7] = t; pendBuf[6] = o; lat += c;
            fieldModel(minutesIn, 59, 1'b0, t, o, c);      pendBuf[5] = t; pendBuf[4] = o; lat += c;
            fieldModel(secondsIn, 59, 1'b0, t, o, c);      pendBuf[3] = t; pendBuf[2] = o; lat += c;
            fieldModel(centisecondsIn, 99, 1'b0, t, o, c); pendBuf[1] = t; pendBuf[0] = o; lat += c;
            pending = 1;
            commitEdge = k + lat;
         end
         expBusy = pending;
         if (!ringSound) ringFrames = 0;
         else if (frameWrap) ringFrames++;
      end
      modelValid = 1'b1;
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clockSignal) begin
      if (modelValid) begin
         vectors++;
         if (digitSelect !== expSel || segments !== expSeg ||
             decimalPoint !== expDp || busy !== expBusy) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t: sel=%h seg=%b dp=%b busy=%b, required sel=%h seg=%b dp=%b busy=%b",
                     $time, digitSelect, segments, decimalPoint, busy, expSel, expSeg, expDp, expBusy);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic setTime(input int h, input int m, input int s, input int cs);
      hoursIn = 5'(h); minutesIn = 6'(m); secondsIn = 6'(s); centisecondsIn = 7'(cs);
   endtask

   logic [6:0] capSeg[8];
   logic       capDp[8];

   // Record the glyph and dot shown at each digit position over n cycles
   task automatic capture(input int n);
      for (int i = 0; i < 8; i++) begin capSeg[i] = 'x; capDp[i] = 1'bx; end
      repeat (n) begin
         @(negedge clockSignal);
         for (int p = 0; p < 8; p++)
            if (digitSelect == ~(8'b1 << p)) begin
               capSeg[p] = segments;
               capDp[p]  = decimalPoint;
            end
      end
   endtask

   task automatic waitBusyRise();
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin @(negedge clockSignal); n++; end
      while (busy !== 1'b1 && n < 200) begin @(negedge clockSignal); n++; end
      if (n >= 200) begin
         vectors++; miscompares++;
         $display("FAIL busy_rise_timeout: got busy=%b, required 1 within 200 cycles", busy);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit found;
      logic [7:0] prev;

      resetSignal = 1'b1; ringSound = 1'b0;
      setTime(0, 0, 0, 0);
      repeat (3) @(negedge clockSignal);
      check("reset_sel",  32'(digitSelect),  32'hFF);
      check("reset_seg",  32'(segments),     32'h7F);
      check("reset_dp",   32'(decimalPoint), 32'h1);
      check("reset_busy", 32'(busy),         32'h0);
      resetSignal = 1'b0;

      // All-zero time: " 0.00.00.00"
      repeat (8 * FRAME) @(negedge clockSignal);
      capture(FRAME);
      check("zero_htens_blank", 32'(capSeg[7]), 32'h7F);
      for (int p = 0; p < 7; p++) check("zero_digit", 32'(capSeg[p]), 32'b1000000);
      for (int p = 0; p < 8; p++) check("zero_dot", 32'(capDp[p]), (p == 2 || p == 4 || p == 6) ? 32'h0 : 32'h1);

      // Worst-case latency 23:59:59.99
      @(negedge clockSignal);
      setTime(23, 59, 59, 99);
      waitBusyRise();
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clockSignal); end
      check("busy_len_max", 32'(cnt), 32'd27);
      repeat (FRAME) @(negedge clockSignal);
      capture(FRAME);
      check("max_htens", 32'(capSeg[7]), 32'b0100100);
      check("max_cones", 32'(capSeg[0]), 32'b0010000);

      // Inputs changed after a snapshot are ignored until the next one
      setTime(12, 34, 56, 78);
      waitBusyRise();
      repeat (2) @(negedge clockSignal);
      setTime(1, 2, 3, 4);
      capture(FRAME - 2);
      check("snap_htens_1", 32'(capSeg[7]), 32'b1111001);
      check("snap_hones_2", 32'(capSeg[6]), 32'b0100100);
      capture(FRAME);
      check("snap_cones_old8", 32'(capSeg[0]), 32'b0000000);
      check("new_htens_blank", 32'(capSeg[7]), 32'h7F);
      check("new_hones_1",     32'(capSeg[6]), 32'b1111001);

      // Out-of-range minutes show dashes only in that field
      setTime(12, 60, 56, 78);
      repeat (2 * FRAME) @(negedge clockSignal);
      capture(FRAME);
      check("oor_mtens_dash", 32'(capSeg[5]), 32'b0111111);
      check("oor_mones_dash", 32'(capSeg[4]), 32'b0111111);
      check("oor_htens", 32'(capSeg[7]), 32'b1111001);
      check("oor_hones", 32'(capSeg[6]), 32'b0100100);
      check("oor_stens", 32'(capSeg[3]), 32'b0010010);
      check("oor_sones", 32'(capSeg[2]), 32'b0000010);
      check("oor_ctens", 32'(capSeg[1]), 32'b1111000);
      check("oor_cones", 32'(capSeg[0]), 32'b0000000);

      // Blink: align to the first displayed index-0 cycle of a frame
      found = 0; cnt = 0;
      while (!found && cnt < 100) begin
         prev = digitSelect;
         @(negedge clockSignal);
         cnt++;
         found = (digitSelect == 8'hFE) && (prev == 8'h7F);
      end
      check("blink_align_found", 32'(found), 32'h1);
      ringSound = 1'b1;
      cnt = 0;
      repeat (8 * FRAME) begin
         @(negedge clockSignal);
         if (digitSelect == 8'hFF) cnt++;
      end
      check("blink_blank_cycles", 32'(cnt), 32'(4 * FRAME));
      cnt = 0;
      while (digitSelect != 8'hFF && cnt < 200) begin @(negedge clockSignal); cnt++; end
      check("blink_blank_seen", 32'(digitSelect), 32'hFF);
      ringSound = 1'b0;
      @(negedge clockSignal);
      check("blink_lit_after_fall", 32'(digitSelect == 8'hFF), 32'h0);

      // Reset during minutes conversion aborts the commit
      setTime(12, 34, 56, 78);
      waitBusyRise();
      repeat (3) @(negedge clockSignal);
      resetSignal = 1'b1;
      @(negedge clockSignal);
      check("abort_sel",  32'(digitSelect),  32'hFF);
      check("abort_seg",  32'(segments),     32'h7F);
      check("abort_dp",   32'(decimalPoint), 32'h1);
      check("abort_busy", 32'(busy),         32'h0);
      resetSignal = 1'b0;
      setTime(1, 2, 3, 4);
      capture(FRAME);
      for (int p = 0; p < 8; p++) check("abort_buffer_blank", 32'(capSeg[p]), 32'h7F);
      repeat (FRAME) @(negedge clockSignal);
      capture(FRAME);
      check("after_htens_blank", 32'(capSeg[7]), 32'h7F);
      check("after_hones_1",     32'(capSeg[6]), 32'b1111001);
      check("after_sones_3",     32'(capSeg[2]), 32'b0110000);
      check("after_cones_4",     32'(capSeg[0]), 32'b0011001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
